// File: rtl/hog_pix_feeder.sv
// hog_pix_feeder: streams one frame of 4-pixel words from word memory
// to the HOG pixel consumer through a small prefetch FIFO.
// Memory reads are issued from an occupancy budget of (FIFO words +
// reads in flight), so the FIFO cannot overflow and no backpressure
// to memory is needed. Delivery is a registered strobe (ready) with
// the word on o_data in the same cycle.
module hog_pix_feeder #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 96,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [4*PIX_W-1:0]   mem_rdata,
  input  logic                 request,
  output logic                 ready,
  output logic [4*PIX_W-1:0]   o_data
);

  localparam int NWORDS = IMG_W * IMG_H / 4;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW     = $clog2(DEPTH + 1);
  localparam int STAGES = 1;

  localparam logic [CW-1:0] NWORDS_C = CW'(NWORDS);
  localparam logic [FW:0]   DEPTH_C  = (FW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [CW-1:0]                  issued, delivered;
  // vld_pipe[0]: read issued this cycle (drives mem_rd)
  // vld_pipe[1]: its data is on mem_rdata this cycle
  logic [STAGES:0]                vld_pipe;
  logic [DEPTH-1:0][4*PIX_W-1:0]  fifo_mem;
  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [FW-1:0]                  fifo_count;
  logic [FW:0]                    occ;
  logic                           frame_go, issue, push, pop;

  assign mem_rd = vld_pipe[0];

  // Issue / push / pop decisions for the coming edge
  always_comb begin
    frame_go = (state == IDLE) && start;
    occ      = {1'b0, fifo_count} + (FW+1)'(vld_pipe[0]) + (FW+1)'(vld_pipe[1]);
    issue    = (state == RUN) && (issued != NWORDS_C) && (occ < DEPTH_C);
    push     = vld_pipe[1];
    pop      = (state == RUN) && request && (fifo_count != '0) &&
               (delivered != NWORDS_C);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (delivered == NWORDS_C) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue: address counter, strobe and in-flight tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      issued   <= '0;
      mem_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      if (frame_go) begin
        issued <= '0;
      end else if (issue) begin
        mem_addr <= ADDR_W'(issued);
        issued   <= issued + CW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FW'(1);
        2'b01:   fifo_count <= fifo_count - FW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered delivery strobe; o_data holds between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready     <= 1'b0;
      o_data    <= '0;
      delivered <= '0;
    end else begin
      ready <= pop;
      if (frame_go) begin
        delivered <= '0;
      end else if (pop) begin
        o_data    <= fifo_mem[rd_ptr];
        delivered <= delivered + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hog_pix_feeder.sv
// Directed bench for hog_pix_feeder: full frames on the default
// geometry plus a one-word frame on a second instance.
module tb_hog_pix_feeder;

  localparam int ADDR_W = 12;
  localparam int NW     = 3840;

  logic              clk = 1'b0;
  logic              rst, start, request;
  logic              busy, done, mem_rd, ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       o_data;
  logic [19:0]       salt = '0;

  logic              start_s, request_s;
  logic              busy_s, done_s, mem_rd_s, ready_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0]       mem_rdata_s = '0;
  logic [31:0]       o_data_s;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  hog_pix_feeder u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .request(request), .ready(ready), .o_data(o_data)
  );

  hog_pix_feeder #(.IMG_W(4), .IMG_H(1)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .mem_rd(mem_rd_s), .mem_addr(mem_addr_s), .mem_rdata(mem_rdata_s),
    .request(request_s), .ready(ready_s), .o_data(o_data_s)
  );

  // Memory models: word k = {salt, k}, one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd)   mem_rdata   <= {salt, mem_addr};
    if (mem_rd_s) mem_rdata_s <= 32'hCAFE0000 | 32'(mem_addr_s);
  end

  // Stream monitor for the main instance
  int n_rd = 0, n_rdy = 0, n_done = 0, cyc = 0;
  int order_err = 0, addr_err = 0, hold_err = 0, viol = 0, max_occ = 0;
  int exp_addr = 0, exp_word = 0, frm_start = 0, frm_first_rdy = -1;
  int last_rdy = 0, done_cyc = 0;
  logic [31:0] first_data = '0, last_o = '0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      last_o = '0;
    end else begin
      cyc++;
      if (start && !busy) begin
        exp_addr = 0; exp_word = 0; frm_start = cyc; frm_first_rdy = -1;
      end
      if (mem_rd) begin
        if (mem_addr !== ADDR_W'(exp_addr)) addr_err++;
        exp_addr++; n_rd++;
      end
      if (ready) begin
        if (o_data !== {salt, 12'(exp_word)}) order_err++;
        if (!busy) viol++;
        if (frm_first_rdy < 0) begin frm_first_rdy = cyc; first_data = o_data; end
        exp_word++; n_rdy++; last_rdy = cyc; last_o = o_data;
      end else if (o_data !== last_o) begin
        hold_err++;
      end
      if (exp_addr - exp_word > max_occ) max_occ = exp_addr - exp_word;
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base, k;
    base = n_done; k = 0;
    while (n_done == base && k < budget) begin step(1); k++; end
    chk(tag, 32'(n_done != base), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_busy"},  32'(busy),   32'd0);
    chk({pfx, "_done"},  32'(done),   32'd0);
    chk({pfx, "_mem_rd"},32'(mem_rd), 32'd0);
    chk({pfx, "_ready"}, 32'(ready),  32'd0);
    chk({pfx, "_odata"}, o_data,      32'd0);
    chk({pfx, "_addr"},  32'(mem_addr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_rdy, b_done, k;
    rst = 1'b0; start = 1'b0; request = 1'b0; start_s = 1'b0; request_s = 1'b0;
    #12;
    chk_outputs_zero("rst");
    chk("rst_small_busy", 32'(busy_s), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    step(2);

    // Frame 1: request held high, word k = k
    request = 1'b1; salt = '0;
    b_rd = n_rd; b_rdy = n_rdy; b_done = n_done;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done_seen", 6000);
    chk("t1_busy_after", 32'(busy), 32'd0);
    step(3);
    chk("t1_ready_cnt", 32'(n_rdy - b_rdy), NW);
    chk("t1_rd_cnt", 32'(n_rd - b_rd), NW);
    chk("t1_done_cnt", 32'(n_done - b_done), 32'd1);
    chk("t1_first_lat", 32'(frm_first_rdy - frm_start), 32'd5);
    chk("t1_b2b_span", 32'(last_rdy - frm_first_rdy), NW - 1);
    chk("t1_done_after_last", 32'(done_cyc - last_rdy), 32'd1);
    chk("t1_first_word", first_data, 32'd0);
    chk("t1_last_word", last_o, 32'd3839);
    chk("t1_order_err", 32'(order_err), 32'd0);
    chk("t1_addr_err", 32'(addr_err), 32'd0);

    // Frame 2: request low for 20 cycles, then toggling each cycle
    request = 1'b0; salt = 20'h5A3C1;
    b_rd = n_rd; b_rdy = n_rdy; b_done = n_done;
    pulse_start();
    step(20);
    chk("t2_prefetch_rd", 32'(n_rd - b_rd), 32'd4);
    chk("t2_no_ready", 32'(n_rdy - b_rdy), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    request = 1'b1;
    step(5);
    chk("t2_burst_cnt", 32'(n_rdy - b_rdy), 32'd4);
    chk("t2_burst_b2b", 32'(last_rdy - frm_first_rdy), 32'd3);
    chk("t2_burst_first", first_data, {20'h5A3C1, 12'd0});
    chk("t2_prefetch_resume", 32'(n_rd - b_rd > 4), 32'd1);
    k = 0;
    while (n_done == b_done && k < 20000) begin request = ~request; step(1); k++; end
    chk("t2_done_seen", 32'(n_done != b_done), 32'd1);
    request = 1'b1;
    step(3);
    chk("t2_ready_cnt", 32'(n_rdy - b_rdy), NW);
    chk("t2_done_cnt", 32'(n_done - b_done), 32'd1);
    chk("t2_order_err", 32'(order_err), 32'd0);
    chk("t2_max_occ_le4", 32'(max_occ <= 4), 32'd1);

    // Frame 3: second start mid-frame must be ignored
    salt = 20'h0F0F0;
    b_rd = n_rd; b_rdy = n_rdy; b_done = n_done;
    pulse_start();
    step(500);
    pulse_start();
    chk("t3_busy", 32'(busy), 32'd1);
    wait_done("t3_done_seen", 6000);
    step(3);
    chk("t3_ready_cnt", 32'(n_rdy - b_rdy), NW);
    chk("t3_rd_cnt", 32'(n_rd - b_rd), NW);
    chk("t3_done_cnt", 32'(n_done - b_done), 32'd1);
    chk("t3_order_err", 32'(order_err), 32'd0);
    chk("t3_addr_err", 32'(addr_err), 32'd0);

    // Frame 4: reset after 100 words with a read in flight, then restart
    salt = 20'h00009;
    b_rdy = n_rdy;
    pulse_start();
    k = 0;
    while (n_rdy - b_rdy < 100 && k < 1000) begin step(1); k++; end
    chk("t4_reached_100", 32'(n_rdy - b_rdy >= 100), 32'd1);
    chk("t4_rd_outstanding", 32'(mem_rd), 32'd1);
    rst = 1'b0;
    #1;
    chk_outputs_zero("t4_rst");
    #2 rst = 1'b1;
    step(2);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_ready", 32'(ready), 32'd0);
    b_rd = n_rd; b_rdy = n_rdy; b_done = n_done;
    pulse_start();
    wait_done("t4_done_seen", 6000);
    step(3);
    chk("t4_first_word", first_data, {20'h00009, 12'd0});
    chk("t4_ready_cnt", 32'(n_rdy - b_rdy), NW);
    chk("t4_rd_cnt", 32'(n_rd - b_rd), NW);
    chk("t4_done_cnt", 32'(n_done - b_done), 32'd1);
    chk("t4_order_err", 32'(order_err), 32'd0);
    chk("t4_addr_err", 32'(addr_err), 32'd0);
    chk("hold_err", 32'(hold_err), 32'd0);
    chk("ready_outside_run", 32'(viol), 32'd0);

    // Single-word frame on the small instance
    request_s = 1'b1;
    start_s = 1'b1; step(1); start_s = 1'b0;
    chk("s_busy", 32'(busy_s), 32'd1);
    chk("s_no_rd_yet", 32'(mem_rd_s), 32'd0);
    step(1);
    chk("s_rd", 32'(mem_rd_s), 32'd1);
    chk("s_addr", 32'(mem_addr_s), 32'd0);
    step(1);
    chk("s_single_rd", 32'(mem_rd_s), 32'd0);
    step(1);
    chk("s_ready_early", 32'(ready_s), 32'd0);
    step(1);
    chk("s_ready", 32'(ready_s), 32'd1);
    chk("s_data", o_data_s, 32'hCAFE0000);
    chk("s_done_early", 32'(done_s), 32'd0);
    step(1);
    chk("s_done", 32'(done_s), 32'd1);
    chk("s_ready_once", 32'(ready_s), 32'd0);
    chk("s_rd_none", 32'(mem_rd_s), 32'd0);
    step(1);
    chk("s_done_once", 32'(done_s), 32'd0);
    chk("s_busy_after", 32'(busy_s), 32'd0);
    chk("s_data_hold", o_data_s, 32'hCAFE0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
